dz_count_ctrl: RTL and testbench

DZ_COUNT_CTRL -- requirements
Module: dz_count_ctrl

---
 rtl/dz_pkg.sv | 18 +
 rtl/dz_debounce.sv | 86 ++++++++
 rtl/dz_count_ctrl.sv | 85 ++++++++
 tb/tb_dz_count_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dz_pkg.sv
// Shared constants for the dot-matrix count controller: count range and
// debounce FSM state encodings.
package dz_pkg;

  localparam int NUM_W = 3;
  localparam logic [NUM_W-1:0] NUM_MAX = 3'd5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PCHK = 2'd1;
  localparam logic [1:0] HELD = 2'd2;
  localparam logic [1:0] RCHK = 2'd3;

  // Modulo-(NUM_MAX+1) increment; anything at or above NUM_MAX folds to zero.
  function automatic logic [NUM_W-1:0] num_incr(input logic [NUM_W-1:0] n);
    return (n >= NUM_MAX) ? '0 : n + 3'd1;
  endfunction

endpackage

// File: rtl/dz_debounce.sv
// Key conditioner: 2-flop synchronizer, press/release debounce FSM with a
// saturating stability counter, and a single-cycle press pulse.
//
// state | meaning
// IDLE  | key released and stable
// PCHK  | key seen high, counting stable-high cycles
// HELD  | press accepted, waiting for release
// RCHK  | key seen low, counting stable-low cycles
module dz_debounce
  import dz_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  logic             sync_q1;
  logic             sync_q2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  assign cnt_done = (cnt >= CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= key;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q2) begin
            state <= PCHK;
            cnt   <= CNT_W'(1);
          end
        end
        PCHK: begin
          if (!sync_q2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= HELD;
            cnt   <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync_q2) begin
            state <= RCHK;
            cnt   <= CNT_W'(1);
          end
        end
        RCHK: begin
          if (sync_q2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dz_count_ctrl.sv
// Modulo-6 key counter feeding the dot-matrix display stage.
// Optional auto-count prescaler enabled by defining DZ_AUTO_COUNT_EN.
module dz_count_ctrl
  import dz_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter logic [25:0] TICK_CYC     = 26'd50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_inc,
  input  logic             btn_clr,
`ifdef DZ_AUTO_COUNT_EN
  input  logic             auto_en,
`endif
  output logic [NUM_W-1:0] num,
  output logic             num_chg
);

  if (TICK_CYC < 26'd2) begin : g_bad_tick
    $error("TICK_CYC must be at least 2");
  end

  logic             inc_press;
  logic             clr_press;
  logic             tick;
  logic [NUM_W-1:0] num_next;

  dz_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (btn_inc),
    .press (inc_press)
  );

  dz_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (btn_clr),
    .press (clr_press)
  );

`ifdef DZ_AUTO_COUNT_EN
  localparam int PRE_W = $clog2(TICK_CYC);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);

  logic [PRE_W-1:0] presc;

  assign tick = auto_en && (presc == PRE_LAST);

  // A clear restarts the tick period so the next tick is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!auto_en || clr_press || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end
`else
  assign tick = 1'b0;
`endif

  // Clear wins; increment and tick together still advance by one.
  always_comb begin
    num_next = num;
    if (clr_press) begin
      num_next = '0;
    end else if (inc_press || tick) begin
      num_next = num_incr(num);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num     <= '0;
      num_chg <= 1'b0;
    end else begin
      num     <= num_next;
      num_chg <= (num_next != num);
    end
  end

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Directed bench for dz_count_ctrl (DEBOUNCE_CYC=4, TICK_CYC=10); auto-count
// checks run only when DZ_AUTO_COUNT_EN is defined.
module tb_dz_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_inc;
  logic       btn_clr;
`ifdef DZ_AUTO_COUNT_EN
  logic       auto_en;
`endif
  logic [2:0] num;
  logic       num_chg;

  int errors = 0;
  int checks = 0;

  dz_count_ctrl #(.DEBOUNCE_CYC(20'd4), .TICK_CYC(26'd10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_inc (btn_inc),
    .btn_clr (btn_clr),
`ifdef DZ_AUTO_COUNT_EN
    .auto_en (auto_en),
`endif
    .num     (num),
    .num_chg (num_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  inc;
    logic  clr;
    int    hold;
    int    exp_num;
    int    exp_pulses;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string nm, input logic i, input logic c,
                         input int h, input int en, input int ep);
    vec_t v;
    v.name = nm; v.inc = i; v.clr = c; v.hold = h;
    v.exp_num = en; v.exp_pulses = ep;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, actual, expected);
    end
  endtask

  // Hold the keys for 'hold' cycles, release, then allow release qualification.
  task automatic apply(input logic i, input logic c, input int hold,
                       output int pulses, output int bad_vals);
    pulses = 0;
    bad_vals = 0;
    btn_inc = i;
    btn_clr = c;
    for (int k = 0; k < hold + 14; k++) begin
      @(negedge clk);
      if (num_chg) pulses++;
      if (num > 3'd5) bad_vals++;
      if (k == hold - 1) begin
        btn_inc = 1'b0;
        btn_clr = 1'b0;
      end
    end
  endtask

  initial begin
    int p, b;
    int glitch [23];

    rst_n = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0;
`ifdef DZ_AUTO_COUNT_EN
    auto_en = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_num", num, 0);
    check("reset_chg", num_chg, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exact latency: key driven before edge t, num changes at edge t+7.
    btn_inc = 1'b1;
    repeat (7) @(negedge clk);
    check("lat_before_num", num, 0);
    check("lat_before_chg", num_chg, 0);
    @(negedge clk);
    check("lat_at_num", num, 1);
    check("lat_at_chg", num_chg, 1);
    @(negedge clk);
    check("lat_after_chg", num_chg, 0);
    p = 0;
    repeat (11) begin
      @(negedge clk);
      if (num_chg) p++;
    end
    btn_inc = 1'b0;
    check("lat_held_no_repeat", p, 0);
    check("lat_held_num", num, 1);
    repeat (14) @(negedge clk);

    apply(1'b0, 1'b1, 20, p, b);
    check("clr_from1_num", num, 0);
    check("clr_from1_pulses", p, 1);

    // Bounce: high 3, low 1, high 3, then low.
    glitch = '{1,1,1,0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    p = 0;
    for (int k = 0; k < 23; k++) begin
      btn_inc = glitch[k][0];
      @(negedge clk);
      if (num_chg) p++;
    end
    check("glitch_num", num, 0);
    check("glitch_pulses", p, 0);

    add_vec("inc_0to1",   1'b1, 1'b0, 20, 1, 1);
    add_vec("inc_1to2",   1'b1, 1'b0, 20, 2, 1);
    add_vec("inc_2to3",   1'b1, 1'b0, 20, 3, 1);
    add_vec("inc_3to4",   1'b1, 1'b0, 20, 4, 1);
    add_vec("inc_4to5",   1'b1, 1'b0, 20, 5, 1);
    add_vec("inc_wrap",   1'b1, 1'b0, 20, 0, 1);
    add_vec("clr_at0",    1'b0, 1'b1, 20, 0, 0);
    add_vec("inc_short",  1'b1, 1'b0, 3,  0, 0);
    add_vec("inc_b1",     1'b1, 1'b0, 20, 1, 1);
    add_vec("inc_b2",     1'b1, 1'b0, 20, 2, 1);
    add_vec("inc_b3",     1'b1, 1'b0, 20, 3, 1);
    add_vec("inc_b4",     1'b1, 1'b0, 20, 4, 1);
    add_vec("inc_clr_4",  1'b1, 1'b1, 20, 0, 1);
    add_vec("inc_long",   1'b1, 1'b0, 40, 1, 1);
    add_vec("clr_from1",  1'b0, 1'b1, 20, 0, 1);

    foreach (vq[i]) begin
      apply(vq[i].inc, vq[i].clr, vq[i].hold, p, b);
      check({vq[i].name, "_num"}, num, vq[i].exp_num);
      check({vq[i].name, "_pulses"}, p, vq[i].exp_pulses);
      check({vq[i].name, "_range"}, b, 0);
    end

    // Asynchronous reset during an in-progress press with num=3.
    repeat (3) apply(1'b1, 1'b0, 20, p, b);
    check("pre_rst_num", num, 3);
    btn_inc = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_num", num, 0);
    check("async_rst_chg", num_chg, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    repeat (20) begin
      @(negedge clk);
      if (num_chg) p++;
    end
    check("requal_num", num, 1);
    check("requal_pulses", p, 1);
    btn_inc = 1'b0;
    repeat (14) @(negedge clk);

`ifdef DZ_AUTO_COUNT_EN
    repeat (4) apply(1'b1, 1'b0, 20, p, b);
    check("auto_pre_num", num, 5);
    auto_en = 1'b1;
    repeat (9) @(negedge clk);
    check("auto_9_num", num, 5);
    @(negedge clk);
    check("auto_10_num", num, 0);
    check("auto_10_chg", num_chg, 1);
    repeat (9) @(negedge clk);
    check("auto_19_num", num, 0);
    @(negedge clk);
    check("auto_20_num", num, 1);
    auto_en = 1'b0;
    p = 0;
    repeat (30) begin
      @(negedge clk);
      if (num_chg) p++;
    end
    check("auto_off_num", num, 1);
    check("auto_off_pulses", p, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
